fg_wave_shaper: RTL and testbench

FG_WAVE_SHAPER -- requirements
Module: fg_wave_shaper

---
 rtl/fg_wave_shaper_if.sv | 35 +++
 rtl/fg_wave_shaper.sv | 154 +++++++++++++++
 tb/tb_fg_wave_shaper.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_wave_shaper_if.sv
`default_nettype none
// ============================================================================
// Module      : fg_wave_shaper_if
// Description : Timer-sample and waveform-output bundle of the wave shaper.
//               master = sample source / consumer, slave = fg_wave_shaper.
// Revision    : 1.0 - initial release
// ============================================================================
interface fg_wave_shaper_if #(
  parameter int COUNTER_BITWIDTH = 32,
  parameter int OUT_BITWIDTH     = 8
);
  logic                        clk_en_i;
  logic [COUNTER_BITWIDTH-1:0] CR_i;
  logic                        timerConfigChanged_i;
  logic                        timerMode_i;
  logic [COUNTER_BITWIDTH-1:0] period_i;
  logic [1:0]                  waveSel_i;
  logic [OUT_BITWIDTH-1:0]     duty_i;
  logic [OUT_BITWIDTH-1:0]     wave_o;
  logic                        valid_o;
  logic                        cycle_o;

  modport master (
    output clk_en_i, CR_i, timerConfigChanged_i, timerMode_i,
           period_i, waveSel_i, duty_i,
    input  wave_o, valid_o, cycle_o
  );

  modport slave (
    input  clk_en_i, CR_i, timerConfigChanged_i, timerMode_i,
           period_i, waveSel_i, duty_i,
    output wave_o, valid_o, cycle_o
  );
endinterface
`default_nettype wire

// File: rtl/fg_wave_shaper.sv
`default_nettype none
// ============================================================================
// Module      : fg_wave_shaper
// Description : Turns timer counter samples into square, sawtooth, triangle
//               or PWM waveform samples through a two-stage pipeline, and
//               resynchronises whenever the timer or wave selection changes.
// Revision    : 1.0 - initial release
// ============================================================================
module fg_wave_shaper #(
  parameter int COUNTER_BITWIDTH = 32,
  parameter int OUT_BITWIDTH     = 8
) (
  input  wire            clk_i,
  input  wire            rstn_i,
  fg_wave_shaper_if.slave bus
);

  localparam int MSB = OUT_BITWIDTH - 1;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              wsel_q, wsel_d;
  logic [MSB:0]            step_q;

  // Stage 1: captured phase, previous captured phase, first-after-sync flag
  logic                    s1_vld_q;
  logic [MSB:0]            s1_p_q;
  logic [MSB:0]            s1_prev_q;
  logic                    s1_first_q;

  // Stage 2: registered outputs
  logic [MSB:0]            wave_q;
  logic                    valid_q;
  logic                    cycle_q;

  logic                    accept;
  logic                    flush;
  logic                    step_inc;
  logic [MSB:0]            phase;
  logic [MSB:0]            tri_t;
  logic [MSB:0]            shape;

  // Sync/run control: a config change always wins over a coincident sample
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    accept  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (bus.clk_en_i && !bus.timerConfigChanged_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          wsel_d  = bus.waveSel_i;
        end
      end
      ST_RUN: begin
        if (bus.timerConfigChanged_i || (bus.waveSel_i != wsel_q)) begin
          flush   = 1'b1;
          state_d = ST_SYNC;
        end else if (bus.clk_en_i) begin
          accept = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Phase source: counter top bits in overflow mode, period-match count in compare mode
  always_comb begin
    phase    = bus.timerMode_i ? bus.CR_i[COUNTER_BITWIDTH-1 -: OUT_BITWIDTH] : step_q;
    step_inc = accept && !bus.timerMode_i && (bus.CR_i == bus.period_i);
  end

  // Waveform generator working on the stage-1 phase
  always_comb begin
    tri_t = {s1_p_q[MSB-1:0], 1'b0};
    case (wsel_q)
      2'b00:   shape = {OUT_BITWIDTH{s1_p_q[MSB]}};
      2'b01:   shape = s1_p_q;
      2'b10:   shape = s1_p_q[MSB] ? ~tri_t : tri_t;
      default: shape = (s1_p_q < bus.duty_i) ? {OUT_BITWIDTH{1'b1}} : {OUT_BITWIDTH{1'b0}};
    endcase
  end

  // Control state, latched wave selection and compare-mode step counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_SYNC;
      wsel_q  <= 2'b00;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      if (flush) begin
        step_q <= '0;
      end else if (step_inc) begin
        step_q <= step_q + OUT_BITWIDTH'(1);
      end
    end
  end

  // Stage 1: capture the phase of each accepted sample
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_vld_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_prev_q  <= '0;
      s1_first_q <= 1'b0;
    end else if (flush) begin
      s1_vld_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_prev_q  <= '0;
      s1_first_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_p_q     <= phase;
        s1_prev_q  <= s1_p_q;
        // The sample that leaves SYNC has no meaningful predecessor
        s1_first_q <= (state_q == ST_SYNC);
      end
    end
  end

  // Stage 2: publish the sample, flag a phase wrap, hold wave between samples
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wave_q  <= '0;
      valid_q <= 1'b0;
      cycle_q <= 1'b0;
    end else if (flush) begin
      wave_q  <= '0;
      valid_q <= 1'b0;
      cycle_q <= 1'b0;
    end else begin
      valid_q <= s1_vld_q;
      cycle_q <= s1_vld_q && !s1_first_q && (s1_p_q < s1_prev_q);
      if (s1_vld_q) begin
        wave_q <= shape;
      end
    end
  end

  assign bus.wave_o  = wave_q;
  assign bus.valid_o = valid_q;
  assign bus.cycle_o = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_fg_wave_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_fg_wave_shaper
// Description : Self-checking bench for fg_wave_shaper: directed vector table,
//               hand-written reset/PWM sequences and randomized stimulus
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_wave_shaper;

  localparam int CBW = 32;
  localparam int OBW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  fg_wave_shaper_if #(.COUNTER_BITWIDTH(CBW), .OUT_BITWIDTH(OBW)) bus ();

  fg_wave_shaper #(.COUNTER_BITWIDTH(CBW), .OUT_BITWIDTH(OBW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit tcc, input bit mode, input bit [1:0] ws,
                       input bit [31:0] cr, input bit [31:0] per, input bit [7:0] duty);
    bus.clk_en_i             = en;
    bus.timerConfigChanged_i = tcc;
    bus.timerMode_i          = mode;
    bus.waveSel_i            = ws;
    bus.CR_i                 = cr;
    bus.period_i             = per;
    bus.duty_i               = duty;
  endtask

  // ---------------- Reference model (transaction level) ----------------
  typedef struct {
    int       due;
    bit [7:0] w;
    bit       c;
  } ev_t;

  ev_t      evq[$];
  bit       m_run;
  bit [1:0] m_wsel;
  int       m_step;
  int       m_prev;
  bit       m_have;
  bit [7:0] m_wave;
  int       cyc;

  function automatic bit [7:0] shape_of(input bit [1:0] ws, input int p, input int d);
    case (ws)
      2'd0:    return (p >= 128) ? 8'hFF : 8'h00;
      2'd1:    return 8'(p);
      2'd2:    return (p < 128) ? 8'(2 * p) : 8'(511 - 2 * p);
      default: return (p < d) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    evq.delete();
    m_run  = 1'b0;
    m_wsel = 2'd0;
    m_step = 0;
    m_prev = 0;
    m_have = 1'b0;
    m_wave = 8'h00;
    cyc    = 0;
  endtask

  // One clock of stimulus, model prediction and output check
  task automatic step(input bit en, input bit tcc, input bit mode, input bit [1:0] ws,
                      input bit [31:0] cr, input bit [31:0] per, input bit [7:0] duty);
    int       p;
    bit       ev;
    bit [7:0] ew;
    bit       ec;
    drive(en, tcc, mode, ws, cr, per, duty);
    if (m_run && (tcc || ws != m_wsel)) begin
      m_run  = 1'b0;
      m_step = 0;
      m_have = 1'b0;
      m_wave = 8'h00;
      evq.delete();
    end else if (en && !tcc) begin
      if (!m_run) begin
        m_run  = 1'b1;
        m_wsel = ws;
      end
      p = mode ? int'(cr[31:24]) : m_step;
      if (!mode && cr == per) m_step = (m_step + 1) % 256;
      evq.push_back('{due: cyc + 2, w: shape_of(m_wsel, p, int'(duty)),
                      c: m_have && (p < m_prev)});
      m_prev = p;
      m_have = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    ev = 1'b0; ew = m_wave; ec = 1'b0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      ev = 1'b1; ew = evq[0].w; ec = evq[0].c;
      m_wave = ew;
      void'(evq.pop_front());
    end
    chk("valid_o", {31'd0, bus.valid_o}, {31'd0, ev});
    chk("wave_o",  {24'd0, bus.wave_o},  {24'd0, ew});
    chk("cycle_o", {31'd0, bus.cycle_o}, {31'd0, ec});
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 8'd0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    bit        en;
    bit        tcc;
    bit [1:0]  ws;
    bit [31:0] cr;
    bit        ev;
    bit [7:0]  ew;
    bit        ec;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Overflow-mode sequences; expected values are the outputs after the row's edge
    tbl[0]  = '{1'b1, 1'b0, 2'd1, 32'h8000_0000, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 1'b1, 8'h80, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 1'b0, 8'h80, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 32'h4000_0000, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'hC000_0000, 1'b1, 8'h80, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 1'b1, 8'h7F, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 32'hF000_0000, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 32'h1000_0000, 1'b1, 8'hFF, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 32'hA000_0000, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 32'h2000_0000, 1'b1, 8'hFF, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 32'h3000_0000, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 32'hFF00_0000, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 8'hFF, 1'b0};

    drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("reset wave_o",  {24'd0, bus.wave_o},  32'd0);
    chk("reset cycle_o", {31'd0, bus.cycle_o}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].en, tbl[i].tcc, 1'b1, tbl[i].ws, tbl[i].cr, 32'd0, 8'd0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d] valid_o", i), {31'd0, bus.valid_o}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl[%0d] wave_o", i),  {24'd0, bus.wave_o},  {24'd0, tbl[i].ew});
      chk($sformatf("tbl[%0d] cycle_o", i), {31'd0, bus.cycle_o}, {31'd0, tbl[i].ec});
    end

    // Compare-mode PWM: period 3, duty 2, counter 0..3 repeating
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 2'd3, 32'(k % 4), 32'd3, 8'd2);
      if (k >= 1) begin
        chk("pwm step-derived wave", {24'd0, bus.wave_o},
            ((k - 1) / 4 < 2) ? 32'hFF : 32'h00);
      end
    end

    // Asynchronous reset mid-run with a sample still in flight
    do_reset();
    step(1'b1, 1'b0, 1'b1, 2'd1, 32'h5500_0000, 32'd0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd1, 32'h6600_0000, 32'd0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd1, 32'h7700_0000, 32'd0, 8'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst wave_o",  {24'd0, bus.wave_o},  32'd0);
    chk("async rst valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("async rst cycle_o", {31'd0, bus.cycle_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 8'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd1, 32'h3300_0000, 32'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'd0, 32'd0, 8'd0);

    // Randomized run against the model; duty/mode/period only move on config-change cycles
    begin
      bit       r_mode = 1'b1;
      bit [1:0] r_ws   = 2'd1;
      bit [7:0] r_duty = 8'd100;
      bit [31:0] r_per = 32'd3;
      bit [31:0] r_cr;
      bit       r_en, r_tcc;
      do_reset();
      for (int n = 0; n < 800; n++) begin
        r_tcc = ($urandom_range(0, 19) == 0);
        r_en  = ($urandom_range(0, 2) != 0);
        if (r_tcc) begin
          r_mode = $urandom_range(0, 1);
          r_per  = $urandom_range(0, 3);
          case ($urandom_range(0, 3))
            0:       r_duty = 8'h00;
            1:       r_duty = 8'hFF;
            default: r_duty = 8'($urandom);
          endcase
        end
        if ($urandom_range(0, 29) == 0) r_ws = 2'($urandom);
        r_cr = r_mode ? $urandom : 32'($urandom_range(0, 3));
        step(r_en, r_tcc, r_mode, r_ws, r_cr, r_per, r_duty);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
